blink_monitor: RTL and testbench

//  Checker/receiver for the blinker's (led, flg) outputs. Measures flg spacing,

---
 rtl/blink_pkg.sv | 28 ++
 rtl/blink_period_cnt.sv | 45 ++++
 rtl/blink_monitor.sv | 130 +++++++++++++
 tb/tb_blink_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared types for the blinker monitor: fault cause codes, monitor states,
// and the nominal flg period derived from the blinker counter width.
package blink_pkg;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    SHORT    = 3'd1,
    LONG     = 3'd2,
    WIDE     = 3'd3,
    LED_SPUR = 3'd4,
    LED_MISS = 3'd5
  } fault_code_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } mon_state_e;

  // Wide enough for any LOCK_COUNT in 1..255.
  localparam int unsigned RUN_W = 8;

  function automatic int unsigned period(input int unsigned cbits);
    return 32'd1 << cbits;
  endfunction

endpackage

// File: rtl/blink_period_cnt.sv
// Interval counter between flg edges: clears on an edge, saturates at P+1, and
// classifies each edge (or the missing one) against the nominal period P.
module blink_period_cnt
  import blink_pkg::*;
#(
  parameter int unsigned CBITS = 12
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flg_edge_i,
  output logic is_good_o,
  output logic is_short_o,
  output logic is_long_o
);

  localparam int unsigned CW = CBITS + 1;
  localparam logic [CW-1:0] CNT_PM1 = CW'(period(CBITS) - 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(period(CBITS) + 1);

  logic [CW-1:0] icnt_q, icnt_d;

  always_comb begin
    icnt_d = icnt_q;
    if (flg_edge_i) begin
      icnt_d = '0;
    end else if (icnt_q != CNT_SAT) begin
      icnt_d = icnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      icnt_q <= '0;
    end else begin
      icnt_q <= icnt_d;
    end
  end

  // icnt == P-1 at an edge means exactly P cycles since the previous edge.
  assign is_good_o  = flg_edge_i & (icnt_q == CNT_PM1);
  assign is_short_o = flg_edge_i & (icnt_q < CNT_PM1);
  // Missing pulse: the count is about to reach P with no edge this cycle.
  assign is_long_o  = ~flg_edge_i & (icnt_q == CNT_PM1);

endmodule

// File: rtl/blink_monitor.sv
// Checker for the blinker's (led, flg) pair: acquires on the first flg edge,
// locks after LOCK_COUNT good periods, and latches the first fault cause.
module blink_monitor
  import blink_pkg::*;
#(
  parameter int unsigned CBITS      = 12,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned GCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              led,
  input  logic              flg,
  output logic              locked,
  output logic              fault,
  output logic [2:0]        fault_code,
  output logic [GCNT_W-1:0] good_periods
);

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);

  logic              led_q, flg_q;
  mon_state_e        state_q, state_d;
  fault_code_e       code_q, code_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [GCNT_W-1:0] good_q, good_d;

  logic        flg_edge;
  logic        is_good, is_short, is_long;
  fault_code_e cause;

  assign flg_edge = flg & ~flg_q;

  blink_period_cnt #(
    .CBITS (CBITS)
  ) u_pcnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .flg_edge_i (flg_edge),
    .is_good_o  (is_good),
    .is_short_o (is_short),
    .is_long_o  (is_long)
  );

  // Highest-priority cause wins when several checks fail on one sample.
  always_comb begin
    cause = NONE;
    if (flg & flg_q) begin
      cause = WIDE;
    end else if (is_short) begin
      cause = SHORT;
    end else if (is_long) begin
      cause = LONG;
    end else if (flg_q & (led == led_q)) begin
      cause = LED_MISS;
    end else if (~flg_q & (led != led_q)) begin
      cause = LED_SPUR;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    run_d   = run_q;
    good_d  = good_q;
    if (clr) begin
      state_d = IDLE;
      code_d  = NONE;
      run_d   = '0;
      good_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flg_edge) begin
            state_d = ACQ;
            run_d   = '0;
            good_d  = '0;
          end
        end
        ACQ, LOCKED: begin
          if (cause != NONE) begin
            state_d = FAULT;
            code_d  = cause;
          end else if (is_good) begin
            if (good_q != '1) begin
              good_d = good_q + GCNT_W'(1);
            end
            if (state_q == ACQ) begin
              run_d = run_q + RUN_W'(1);
              if (run_q == RUN_LAST) begin
                state_d = LOCKED;
              end
            end
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q   <= 1'b0;
      flg_q   <= 1'b0;
      state_q <= IDLE;
      code_q  <= NONE;
      run_q   <= '0;
      good_q  <= '0;
    end else begin
      led_q   <= led;
      flg_q   <= flg;
      state_q <= state_d;
      code_q  <= code_d;
      run_q   <= run_d;
      good_q  <= good_d;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign fault        = (state_q == FAULT);
  assign fault_code   = code_q;
  assign good_periods = good_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Randomized bench for blink_monitor: a blinker stimulus generator with fault
// injection, checked every cycle against a cycle-index based reference model.
module tb_blink_monitor;

  localparam int P    = 16;
  localparam int LOCK = 4;
  localparam int GW   = 4;
  localparam int GMAX = 15;

  logic          clk = 1'b0;
  logic          rst, clr, led, flg;
  logic          locked, fault;
  logic [2:0]    fault_code;
  logic [GW-1:0] good_periods;

  always #5 clk = ~clk;

  blink_monitor #(
    .CBITS      (4),
    .LOCK_COUNT (LOCK),
    .GCNT_W     (GW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .led          (led),
    .flg          (flg),
    .locked       (locked),
    .fault        (fault),
    .fault_code   (fault_code),
    .good_periods (good_periods)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: reasons about sample indices and the gap between edges.
  int cyc = 0;
  int last_edge;
  bit pf, pl;
  bit m_arm, m_lock, m_fault;
  int m_code, m_good, m_run;

  task automatic model_reset();
    pf = 0; pl = 0;
    m_arm = 0; m_lock = 0; m_fault = 0;
    m_code = 0; m_good = 0; m_run = 0;
    last_edge = -1000;
  endtask

  task automatic model_step(input bit f, input bit l, input bit c);
    bit e;
    int gap, cause;
    e     = f && !pf;
    gap   = cyc - last_edge;
    cause = 0;
    if (c) begin
      m_arm = 0; m_lock = 0; m_fault = 0; m_code = 0; m_good = 0; m_run = 0;
    end else if (m_fault) begin
      m_code = m_code;
    end else if (!m_arm) begin
      if (e) begin
        m_arm = 1; m_good = 0; m_run = 0;
      end
    end else begin
      if (f && pf)               cause = 3;
      else if (e && gap < P)     cause = 1;
      else if (!e && gap == P)   cause = 2;
      else if (pf && l == pl)    cause = 5;
      else if (!pf && l != pl)   cause = 4;
      if (cause != 0) begin
        m_fault = 1; m_code = cause; m_lock = 0; m_arm = 0;
      end else if (e && gap == P) begin
        if (m_good < GMAX) m_good++;
        m_run++;
        if (m_run >= LOCK) m_lock = 1;
      end
    end
    if (e) last_edge = cyc;
    pf = f;
    pl = l;
    cyc++;
  endtask

  task automatic compare_all();
    check("locked", locked, m_lock);
    check("fault", fault, m_fault);
    check("fault_code", fault_code, m_code);
    check("good_periods", good_periods, m_good);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic tick(input bit f, input bit l, input bit c);
    flg = f; led = l; clr = c;
    @(posedge clk);
    model_step(f, l, c);
    @(negedge clk);
    compare_all();
  endtask

  // Blinker model: flg every P cycles, led toggles the cycle after flg.
  int ph;
  bit bled;

  task automatic bl_step(input bit c);
    bit f;
    f = (ph == P - 1);
    tick(f, bled, c);
    bled ^= f;
    ph = (ph + 1) % P;
  endtask

  task automatic run_to_edge();
    while (ph != P - 1) bl_step(0);
    bl_step(0);
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; flg = 1'b0; led = 1'b0;
    #1;
    check("rst_locked", locked, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_good", good_periods, 0);
    model_reset();
    @(negedge clk);
    rst  = 1'b0;
    ph   = $urandom_range(0, P - 1);
    bled = 1'b0;
  endtask

  task automatic inject(input int k);
    case (k)
      1: begin tick(1, bled, 0); bled ^= 1; ph = 0; end
      2: begin while (ph != P - 1) bl_step(0); tick(0, bled, 0); ph = 0; end
      3: begin
        while (ph != P - 1) bl_step(0);
        tick(1, bled, 0); bled ^= 1;
        tick(1, bled, 0); ph = 0;
      end
      4: begin bled ^= 1; bl_step(0); end
      5: begin while (ph != P - 1) bl_step(0); tick(1, bled, 0); ph = 0; end
      default: bl_step(0);
    endcase
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; flg = 1'b0; led = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    repeat (5 * P + 4) bl_step(0);
    check("lock_after4", locked, 1);
    check("lock_nofault", fault, 0);

    run_to_edge();
    repeat (9) bl_step(0);
    inject(1);
    check("short_code", fault_code, 1);
    check("short_fault", fault, 1);
    check("short_unlock", locked, 0);

    bl_step(1);
    check("clr_fault", fault, 0);
    check("clr_code", fault_code, 0);
    check("clr_good", good_periods, 0);

    run_to_edge();
    repeat (P - 1) bl_step(0);
    check("long_early", fault, 0);
    tick(0, bled, 0); ph = 0;
    check("long_code", fault_code, 2);

    bl_step(1);
    run_to_edge();
    inject(3);
    check("wide_code", fault_code, 3);

    bl_step(1);
    run_to_edge();
    repeat (5) bl_step(0);
    inject(4);
    check("spur_code", fault_code, 4);

    bl_step(1);
    run_to_edge();
    inject(5);
    bl_step(0);
    check("miss_code", fault_code, 5);

    bl_step(1);
    repeat (6 * P) bl_step(0);
    check("relock", locked, 1);
    check("relock_nofault", fault, 0);

    do_reset();
    repeat (18 * P) bl_step(0);
    check("sat_good", good_periods, GMAX);
    check("sat_locked", locked, 1);
    check("sat_nofault", fault, 0);

    for (int ep = 0; ep < 40; ep++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      else bl_step(1);
      repeat ($urandom_range(P, 6 * P)) bl_step(0);
      inject($urandom_range(0, 5));
      repeat ($urandom_range(4, 2 * P)) bl_step(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
